mst_reset_seq: RTL and testbench
================================

Name: mst_reset_seq

Overview:
- Reset sequencer and requester arbiter for the MIDI router's reset tree.
- Consumes the master reset, and accepts soft-reset requests from NREQ requesters (e.g. router soft reset, UART framing-error recovery).
- Drives NDOM downstream active-low domain resets: all domains assert together, then release one by one in index order with fixed spacing.
- Latches the cause of the most recent sequence for host readback.

Parameters:
NDOM, 3, number of downstream reset domains (1..8)
NREQ, 2, number of soft-reset requesters (1..8)
HOLD, 16, cycles all domains stay asserted before first release (>=1)
STEP, 4, cycles between successive domain releases (>=1)
WDOG_CYCLES, 65536, watchdog timeout in cycles (used only with the optional feature)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset (master reset)
req  input  NREQ  per-requester soft-reset request, level; held until ack
ack  output  NREQ  one-cycle pulse per accepted request bit
kick  input  1  watchdog kick pulse (optional feature)
rst_n_out  output  NDOM  per-domain active-low reset, registered
done  output  1  high while all domains are released (state RUN)
cause  output  NREQ+1  cause of last sequence: bit NREQ = watchdog, bits[NREQ-1:0] = requester(s); 0 = power-on

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=ASSERT, cnt=0, dom=0.
  - rst_n_out=0, ack=0, done=0, cause=0, watchdog counter=0.
- States:
  - ASSERT: all rst_n_out=0. cnt counts 0..HOLD-1. At cnt==HOLD-1: rst_n_out[0]<=1, dom<=1, cnt<=0.
    - If NDOM==1: go to RUN instead.
    - Otherwise: go to RELEASE.
  - RELEASE: cnt counts 0..STEP-1. At cnt==STEP-1: rst_n_out[dom]<=1, cnt<=0.
    - If dom==NDOM-1: go to RUN.
    - Otherwise: dom<=dom+1.
  - RUN: rst_n_out all 1, done=1. When |req: cause<={1'b0,req}, ack<=req (one cycle), rst_n_out<=0, done<=0, cnt<=0, go to ASSERT.
- Timing: counting the first rising edge after reset_n deasserts (or after the request-accept edge) as edge 1:
  - rst_n_out[k] rises at edge HOLD + k*STEP.
  - done rises on the same edge as rst_n_out[NDOM-1].
- Released domains stay released; no domain re-asserts except via a new sequence.
- Request handling:
  - req is sampled only in RUN. Requests during ASSERT/RELEASE are neither acked nor lost; the requester holds req until ack.
  - All simultaneously high req bits are accepted and acked together. cause records every one of them (no priority drop).
  - A req still high the cycle after its ack starts another sequence once RUN is reached again. Requesters must drop req on ack.
- ack is never high outside the accept cycle. cause holds its value until the next accept.
- Counter width: $clog2(max(HOLD,STEP)+1). Never wraps; it resets to 0 at each transition.
- reset_n asserted mid-sequence: immediate return to the reset state. cause is cleared to 0.

Optional Feature:
MST_RESET_SEQ_WDOG_EN
- Defined:
  - A 32-bit watchdog counter runs only in RUN. It clears on kick=1 and on leaving RUN.
  - On reaching WDOG_CYCLES-1 without a kick: cause<={1'b1,NREQ'b0}, go to ASSERT as for a request, no ack.
  - If req and the timeout coincide, the request wins: ack is issued and cause bit NREQ=0.
- Not defined: no counter is built, kick is ignored, and cause[NREQ] is tied to 0.

Test Plan:
- Power-on, defaults: release reset_n -> rst_n_out[0] rises at edge 16, [1] at edge 20, [2] and done at edge 24; cause=0, ack=0 throughout.
- In RUN, pulse req=2'b10 until ack -> ack=2'b10 for exactly one cycle, rst_n_out=3'b000 the next cycle, cause=3'b010, re-release at edges 16/20/24 after accept.
- req=2'b11 in same RUN cycle -> ack=2'b11 one cycle, cause=3'b011.
- req[0] raised at edge 10 of ASSERT and held -> no ack until done=1; accepted the first RUN cycle, then a new sequence starts.
- Drop reset_n at edge 18 (domain 0 released) -> all rst_n_out=0 and cause=0 asynchronously; full sequence restarts on reset_n release.
- With MST_RESET_SEQ_WDOG_EN, WDOG_CYCLES=100, no kick -> new sequence 100 cycles after done, cause=3'b100. With kick every 50 cycles -> no sequence.

Source files
------------

// File: rtl/mst_reset_seq.sv
// Reset sequencer for the MIDI router reset tree: asserts all domains, releases them in order, arbitrates soft-reset requests.
// Optional watchdog enabled by defining MST_RESET_SEQ_WDOG_EN.
module mst_reset_seq #(
  parameter int NDOM        = 3,
  parameter int NREQ        = 2,
  parameter int HOLD        = 16,
  parameter int STEP        = 4,
  parameter int WDOG_CYCLES = 65536
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] ack,
  input  logic            kick,
  output logic [NDOM-1:0] rst_n_out,
  output logic            done,
  output logic [NREQ:0]   cause
);

  localparam int CMAX = (HOLD > STEP) ? HOLD : STEP;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int DW   = $clog2(NDOM + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD - 1);
  localparam logic [CW-1:0] STEP_LAST = CW'(STEP - 1);
  localparam logic [DW-1:0] DOM_LAST  = DW'(NDOM - 1);

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   dom_q, dom_d;
  logic [NDOM-1:0] rst_q, rst_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            done_q, done_d;
  logic [NREQ:0]   cause_q, cause_d;
  logic            accept_s;
  logic            timeout_s;

  assign accept_s = (state_q == ST_RUN) && (|req);

`ifdef MST_RESET_SEQ_WDOG_EN
  localparam logic [31:0] WDOG_LAST = 32'(WDOG_CYCLES - 1);
  logic [31:0] wdog_q, wdog_d;

  // A request in the same cycle as the timeout takes precedence.
  assign timeout_s = (state_q == ST_RUN) && !kick && (wdog_q == WDOG_LAST);

  always_comb begin
    if ((state_q == ST_RUN) && !accept_s && !timeout_s && !kick) wdog_d = wdog_q + 32'd1;
    else                                                          wdog_d = 32'd0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wdog_q <= 32'd0;
    else          wdog_q <= wdog_d;
  end
`else
  localparam int unused_wdog_cycles = WDOG_CYCLES;
  logic unused_kick_s;
  assign unused_kick_s = kick;
  assign timeout_s     = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_ASSERT;
      cnt_q   <= '0;
      dom_q   <= '0;
      rst_q   <= '0;
      ack_q   <= '0;
      done_q  <= 1'b0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dom_q   <= dom_d;
      rst_q   <= rst_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ASSERT: begin
        if (cnt_q == HOLD_LAST) state_d = (NDOM == 1) ? ST_RUN : ST_RELEASE;
        else                    state_d = ST_ASSERT;
      end
      ST_RELEASE: begin
        if ((cnt_q == STEP_LAST) && (dom_q == DOM_LAST)) state_d = ST_RUN;
        else                                             state_d = ST_RELEASE;
      end
      ST_RUN: begin
        if (accept_s || timeout_s) state_d = ST_ASSERT;
        else                       state_d = ST_RUN;
      end
      default: state_d = ST_ASSERT;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    dom_d   = dom_q;
    rst_d   = rst_q;
    ack_d   = '0;
    done_d  = done_q;
    cause_d = cause_q;
    case (state_q)
      ST_ASSERT: begin
        rst_d = '0;
        if (cnt_q == HOLD_LAST) begin
          rst_d[0] = 1'b1;
          dom_d    = DW'(1);
          cnt_d    = '0;
          done_d   = (NDOM == 1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RELEASE: begin
        if (cnt_q == STEP_LAST) begin
          for (int i = 0; i < NDOM; i++) rst_d[i] = rst_q[i] | (dom_q == DW'(i));
          cnt_d = '0;
          if (dom_q == DOM_LAST) done_d = 1'b1;
          else                   dom_d  = dom_q + DW'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RUN: begin
        if (accept_s) begin
          cause_d = {1'b0, req};
          ack_d   = req;
          rst_d   = '0;
          done_d  = 1'b0;
          cnt_d   = '0;
          dom_d   = '0;
        end else if (timeout_s) begin
          cause_d = {1'b1, {NREQ{1'b0}}};
          rst_d   = '0;
          done_d  = 1'b0;
          cnt_d   = '0;
          dom_d   = '0;
        end else begin
          rst_d = '1;
        end
      end
      default: begin
        rst_d  = '0;
        done_d = 1'b0;
        cnt_d  = '0;
        dom_d  = '0;
      end
    endcase
  end

  assign ack       = ack_q;
  assign rst_n_out = rst_q;
  assign done      = done_q;
  assign cause     = cause_q;

endmodule

// File: tb/tb_mst_reset_seq.sv
// Randomized self-checking bench for mst_reset_seq against an edge-count reference model.
// Watchdog checks are compiled in when MST_RESET_SEQ_WDOG_EN is defined.
module tb_mst_reset_seq;
  localparam int NDOM   = 3;
  localparam int NREQ   = 2;
  localparam int HOLD   = 16;
  localparam int STEP   = 4;
  localparam int WDOG   = 100;
  localparam int T_DONE = HOLD + (NDOM - 1) * STEP;

  logic            clk     = 1'b0;
  logic            reset_n = 1'b0;
  logic            kick    = 1'b0;
  logic [NREQ-1:0] req     = '0;
  logic [NREQ-1:0] ack;
  logic [NDOM-1:0] rst_n_out;
  logic            done;
  logic [NREQ:0]   cause;

  always #5 clk = ~clk;

  mst_reset_seq #(
    .NDOM(NDOM), .NREQ(NREQ), .HOLD(HOLD), .STEP(STEP), .WDOG_CYCLES(WDOG)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .ack(ack), .kick(kick),
    .rst_n_out(rst_n_out), .done(done), .cause(cause)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: edges since the sequence started; each domain k is released once HOLD+k*STEP edges have passed.
  int              m_e;
  int              m_w;
  logic [NREQ-1:0] m_ack;
  logic [NREQ:0]   m_cause;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_e     <= 0;
      m_w     <= 0;
      m_ack   <= '0;
      m_cause <= '0;
    end else if (m_e >= T_DONE && req != '0) begin
      m_e     <= 0;
      m_w     <= 0;
      m_ack   <= req;
      m_cause <= {1'b0, req};
    end
`ifdef MST_RESET_SEQ_WDOG_EN
    else if (m_e >= T_DONE && !kick && m_w == WDOG - 1) begin
      m_e     <= 0;
      m_w     <= 0;
      m_ack   <= '0;
      m_cause <= {1'b1, {NREQ{1'b0}}};
    end
`endif
    else begin
      m_ack <= '0;
      if (m_e < 1000000) m_e <= m_e + 1;
      m_w <= (m_e >= T_DONE && !kick) ? m_w + 1 : 0;
    end
  end

  logic [NDOM-1:0] e_rst;

  always @(negedge clk) begin
    for (int k = 0; k < NDOM; k++) e_rst[k] = (m_e >= HOLD + k * STEP);
    check_eq("rst_n_out", rst_n_out, e_rst);
    check_eq("done", done, (m_e >= T_DONE));
    check_eq("ack", ack, m_ack);
    check_eq("cause", cause, m_cause);
  end

  task automatic wait_done();
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clk);
      #1;
    end
    if (!done) check_eq("wait_done", done, 1);
  endtask

  task automatic measure(input string tag, input int start);
    int r0 = 0, r1 = 0, r2 = 0, rd = 0;
    for (int e = start; e <= 40; e++) begin
      @(posedge clk);
      #1;
      if (r0 == 0 && rst_n_out[0]) r0 = e;
      if (r1 == 0 && rst_n_out[1]) r1 = e;
      if (r2 == 0 && rst_n_out[2]) r2 = e;
      if (rd == 0 && done)         rd = e;
    end
    check_eq({tag, "_rel0"}, r0, 16);
    check_eq({tag, "_rel1"}, r1, 20);
    check_eq({tag, "_rel2"}, r2, 24);
    check_eq({tag, "_done"}, rd, 24);
  endtask

  // Returns one cycle after the accept edge (edge 1 of the new sequence).
  task automatic do_req(input string tag, input logic [NREQ-1:0] r);
    bit got = 1'b0;
    wait_done();
    @(negedge clk);
    #2 req = r;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk);
      #1;
      if (ack != '0) got = 1'b1;
    end
    check_eq({tag, "_ack"}, ack, r);
    check_eq({tag, "_cause"}, cause, {1'b0, r});
    req = '0;
    @(posedge clk);
    #1;
    check_eq({tag, "_ack_pulse"}, ack, 0);
    check_eq({tag, "_asserted"}, rst_n_out, 0);
  endtask

  initial begin
    int ack_e;
    repeat (3) @(negedge clk);
    check_eq("por_rst", rst_n_out, 0);
    check_eq("por_done", done, 0);
    check_eq("por_cause", cause, 0);
    check_eq("por_ack", ack, 0);
    #2 reset_n = 1'b1;
    measure("por", 1);

    do_req("req10", 2'b10);
    measure("rereq", 2);
    do_req("req11", 2'b11);

    // Request raised mid-sequence must wait for RUN.
    repeat (9) @(posedge clk);
    #1 req = 2'b01;
    ack_e = 0;
    for (int e = 11; e <= 60 && ack_e == 0; e++) begin
      @(posedge clk);
      #1;
      if (ack != '0) ack_e = e;
    end
    check_eq("late_ack_edge", ack_e, T_DONE + 1);
    check_eq("late_ack", ack, 2'b01);
    check_eq("late_cause", cause, 3'b001);
    req = '0;

    repeat (18) @(posedge clk);
    #1 check_eq("mid_rst", rst_n_out, 3'b001);
    #1 reset_n = 1'b0;
    #1;
    check_eq("async_rst", rst_n_out, 0);
    check_eq("async_cause", cause, 0);
    check_eq("async_done", done, 0);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    measure("restart", 1);

`ifdef MST_RESET_SEQ_WDOG_EN
    ack_e = 0;
    for (int e = 41; e <= 300 && ack_e == 0; e++) begin
      @(posedge clk);
      #1;
      if (!done) ack_e = e;
    end
    check_eq("wdog_edge", ack_e, T_DONE + WDOG);
    check_eq("wdog_cause", cause, 3'b100);
    check_eq("wdog_ack", ack, 0);
    wait_done();
    for (int p = 0; p < 8; p++) begin
      repeat (49) @(negedge clk);
      #2 kick = 1'b1;
      @(negedge clk);
      #2 kick = 1'b0;
      check_eq("kick_done", done, 1);
    end
`endif

    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      #2;
      req = req & ~ack;
      if ($urandom_range(0, 39) == 0) req = req | NREQ'($urandom_range(1, 3));
      kick = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 699) == 0) begin
        reset_n = 1'b0;
        #1;
        check_eq("rand_async_rst", rst_n_out, 0);
        check_eq("rand_async_cause", cause, 0);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
      end
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
